// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: controller states and instruction-queue entry layout.
package fetch_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned FQ_XLEN     = 32;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_WAIT,
        FS_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] pc_plus;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch bus: instruction-memory request/response channel plus the decode-side queue head.
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               fetch_valid;
    logic               fetch_ready;
    logic [INSTR_W-1:0] fetch_instr;
    logic [XLEN-1:0]    fetch_instr_addr;
    logic [XLEN-1:0]    fetch_instr_addr_plus;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output fetch_valid, fetch_instr, fetch_instr_addr, fetch_instr_addr_plus,
        input  fetch_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  fetch_valid, fetch_instr, fetch_instr_addr, fetch_instr_addr_plus,
        output fetch_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; flush overrides push and pop in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: single-outstanding instruction-memory requester feeding a DEPTH-entry queue to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FQ_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid_i,
    input  logic [XLEN-1:0]            redirect_addr_i,
    fetch_queue_if.master              bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    fetch_state_e                 state_q, state_d;
    logic [XLEN-1:0]              pc_q, pc_d;
    logic [XLEN-1:0]              req_pc_q, req_pc_d;
    logic                         req_fire, push, pop;
    logic                         fifo_full, fifo_empty;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;
    fetch_entry_t                 push_entry, head_entry;

    // The slot for a response is reserved at issue: only request while the queue has room.
    assign bus.imem_req_valid = !rst && (state_q == FS_REQ) && !fifo_full;
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign push               = (state_q == FS_WAIT) && bus.imem_rsp_valid && !redirect_valid_i;
    assign pop                = bus.fetch_valid && bus.fetch_ready;

    assign push_entry.instr   = bus.imem_rsp_data;
    assign push_entry.pc      = req_pc_q;
    assign push_entry.pc_plus = req_pc_q + STEP;

    assign bus.fetch_valid           = !rst && !fifo_empty;
    assign bus.fetch_instr           = head_entry.instr;
    assign bus.fetch_instr_addr      = head_entry.pc;
    assign bus.fetch_instr_addr_plus = head_entry.pc_plus;
    assign occupancy_o               = rst ? '0 : fifo_count;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid_i),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            FS_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + STEP;
                    state_d  = FS_WAIT;
                end
            end
            FS_WAIT: if (bus.imem_rsp_valid) state_d = FS_REQ;
            FS_DROP: if (bus.imem_rsp_valid) state_d = FS_REQ;
            default: state_d = FS_REQ;
        endcase
        // A redirect turns any still-pending request (new or old) into a stale one.
        if (redirect_valid_i) begin
            pc_d = redirect_addr_i & ALIGN_MASK;
            if (state_d == FS_WAIT) state_d = FS_DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FS_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    rsp_outside_request_a: assert property (
        @(posedge clk) disable iff (rst) !((state_q == FS_REQ) && bus.imem_rsp_valid)
    );

endmodule
